fa_decimate_sequencer: RTL
==========================

Name: fa_decimate_sequencer

Overview:
Front-end controller for the FA-rate CIC decimator bank.
- Accepts one parallel sample vector per RF/turn strobe, holding all channels.
- Serialises the vector into the channel-indexed stream the decimator consumes: channel 0 first, one channel per clock.
- Generates the decimation flag that marks each FA output boundary, and the matching CIC output shift.
- Turns-per-sample changes are applied only on a decimation boundary, so no FA output ever mixes two decimation ratios.

Parameters:
DATA_WIDTH, 24, width of one channel sample
CHANNEL_WIDTH, 2, width of channel index
LAST_CHAN, 3, highest channel index (LAST_CHAN+1 channels)
DECIMATION_FACTOR, 152, CIC decimation at one turn per sample; must be divisible by 8
STAGES, 3, CIC stage count, used for shift computation

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
log2Turns  in  2  log2 of turns per RF sample (0..3)
syncMarker  in  1  single-cycle request to realign decimation boundary
sampleStrobe  in  1  single-cycle: sampleData valid
sampleData  in  (LAST_CHAN+1)*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
outputData  out  DATA_WIDTH  serialised sample
outputChannel  out  CHANNEL_WIDTH  channel index of outputData
outputValid  out  1  outputData/outputChannel valid
decimateFlag  out  1  boundary flag; meaningful when outputValid && outputChannel==0
cicShift  out  4  CIC output shift for active configuration
busy  out  1  serialiser occupied
overrun  out  1  sticky: strobe dropped
clearOverrun  in  1  clears overrun

Behaviour:
- Reset values:
  - outputData=0, outputChannel=0, outputValid=0, decimateFlag=0, cicShift=0, busy=0, overrun=0.
  - Internal: decCount=0, activeLog2=0, syncPending=0, state=IDLE.
- Reset is asynchronous and may arrive mid-serialisation. The vector in progress is abandoned with no further outputValid. The first accepted strobe after reset is a boundary.
- FSM has two states, IDLE and SHIFT.
  - A strobe is accepted when state==IDLE, or when state==SHIFT and the channel being emitted this cycle is LAST_CHAN. Back-to-back vectors therefore stream with no gap.
  - Accept: latch sampleData, go to/stay in SHIFT, emit channel index 0 next.
  - SHIFT: emit one channel per cycle. After emitting LAST_CHAN, return to IDLE unless a new strobe was accepted that cycle.
  - A strobe at any other time is dropped and sets overrun. If clearOverrun and a drop occur in the same cycle, overrun stays set.
- Latency: strobe at cycle t gives outputValid with channel k at cycle t+1+k; outputValid is registered.
- busy=1 exactly on cycles where outputValid=1.
- Decimation count: effective decimation D = DECIMATION_FACTOR >> activeLog2.
  - On each accepted strobe:
    - Boundary when decCount==0, or when syncMarker is high this cycle, or when syncPending is set.
    - On a boundary:
      - decimateFlag=1 on this vector's channel-0 beat.
      - activeLog2 <= log2Turns.
      - decCount <= (DECIMATION_FACTOR>>log2Turns)-1, using the new value.
      - syncPending cleared.
    - Otherwise decimateFlag=0 and decCount decrements.
  - decimateFlag holds its value for all beats of the vector.
- syncMarker asserted on a cycle with no accepted strobe sets syncPending. Repeated markers collapse to one.
- cicShift = min(15, STAGES*activeLog2).
  - Updated in the same cycle decimateFlag=1 is presented for channel 0, and constant between boundaries.
- A log2Turns change between boundaries has no effect until the next boundary.

Test Plan:
- Bench overrides: DECIMATION_FACTOR=8, LAST_CHAN=3.
- Reset, log2Turns=0, strobes every 4 clocks with sampleData={4,3,2,1}:
  - Outputs channels 0..3 with data 1,2,3,4 at t+1..t+4.
  - decimateFlag=1 on vectors 0, 8 and 16, 0 otherwise; cicShift=0.
- Strobes every clock, then every 4 clocks:
  - Back-to-back strobes: a strobe accepted on the LAST_CHAN beat gives a gapless stream.
  - A strobe at beat 1 is dropped; overrun=1 and holds until clearOverrun.
- log2Turns changed 0->2 at vector 3:
  - Vectors 4..7 are unaffected.
  - Boundary at vector 8; subsequent boundaries every 2 vectors (8>>2).
  - cicShift becomes 6 at vector 8 (STAGES=3).
- log2Turns=3 with STAGES=6 -> cicShift saturates at 15; D=1, so every vector is flagged.
- syncMarker at an idle cycle before vector 5 -> vector 5 flagged, then vector 13. A syncMarker coincident with the vector-6 strobe -> vector 6 flagged.
- Reset asserted during the channel-1 beat:
  - outputValid drops asynchronously and no further beats are emitted.
  - The next strobe is flagged and cicShift=0.

Source files
------------

// File: rtl/fa_decimate_sequencer.sv
// fa_decimate_sequencer: serialises per-strobe channel vectors and marks CIC decimation boundaries
//   clk_i / reset_i       : clock, asynchronous active-high reset
//   log2Turns_i           : log2 of turns per RF sample, adopted only on a boundary
//   syncMarker_i          : forces the next accepted vector to be a boundary
//   sampleStrobe_i        : sampleData_i valid this cycle
//   sampleData_i          : all channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   outputData_o/Channel_o/Valid_o : serialised stream, channel 0 first
//   decimateFlag_o        : boundary flag, held for every beat of the vector
//   cicShift_o            : min(15, STAGES*active log2Turns)
//   busy_o                : serialiser occupied
//   overrun_o / clearOverrun_i : sticky dropped-strobe flag and its clear
module fa_decimate_sequencer #(
    parameter int DATA_WIDTH        = 24,
    parameter int CHANNEL_WIDTH     = 2,
    parameter int LAST_CHAN         = 3,
    parameter int DECIMATION_FACTOR = 152,
    parameter int STAGES            = 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [1:0]                            log2Turns_i,
    input  logic                                  syncMarker_i,
    input  logic                                  sampleStrobe_i,
    input  logic [(LAST_CHAN+1)*DATA_WIDTH-1:0]   sampleData_i,
    output logic [DATA_WIDTH-1:0]                 outputData_o,
    output logic [CHANNEL_WIDTH-1:0]              outputChannel_o,
    output logic                                  outputValid_o,
    output logic                                  decimateFlag_o,
    output logic [3:0]                            cicShift_o,
    output logic                                  busy_o,
    output logic                                  overrun_o,
    input  logic                                  clearOverrun_i
);
    localparam int VW = (LAST_CHAN+1)*DATA_WIDTH;
    localparam int CW = $clog2(DECIMATION_FACTOR+1);
    localparam logic [CW-1:0] DF = CW'(DECIMATION_FACTOR);
    localparam logic [CHANNEL_WIDTH-1:0] LAST = CHANNEL_WIDTH'(LAST_CHAN);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state_q, state_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic [VW-1:0]            data_q, data_d;
    logic [DATA_WIDTH-1:0]    out_q, out_d;
    logic                     flag_q, flag_d;
    logic [CW-1:0]            dec_q, dec_d;
    logic [1:0]               log2_q, log2_d;
    logic                     sync_q, sync_d;
    logic                     ovr_q, ovr_d;
    logic                     last_beat, accept, boundary;
    logic [31:0]              shift_full;

    always_comb begin
        last_beat = (state_q == SHIFT) && (chan_q == LAST);
        // a new vector may start on the final beat so the stream stays gapless
        accept    = sampleStrobe_i && ((state_q == IDLE) || last_beat);
        boundary  = (dec_q == '0) || syncMarker_i || sync_q;
        state_d   = state_q;
        chan_d    = chan_q;
        data_d    = data_q;
        out_d     = out_q;
        flag_d    = flag_q;
        dec_d     = dec_q;
        log2_d    = log2_q;
        if (accept) begin
            state_d = SHIFT;
            chan_d  = '0;
            out_d   = sampleData_i[DATA_WIDTH-1:0];
            data_d  = sampleData_i >> DATA_WIDTH;
            flag_d  = boundary;
            log2_d  = boundary ? log2Turns_i : log2_q;
            dec_d   = boundary ? (DF >> log2Turns_i) - CW'(1) : dec_q - CW'(1);
        end else if (state_q == SHIFT) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                chan_d = chan_q + CHANNEL_WIDTH'(1);
                out_d  = data_q[DATA_WIDTH-1:0];
                data_d = data_q >> DATA_WIDTH;
            end
        end
        // an accepted vector consumes any pending sync (it is then a boundary)
        sync_d = accept ? 1'b0 : (sync_q || syncMarker_i);
        // a drop wins over a simultaneous clear
        ovr_d  = (sampleStrobe_i && !accept) || (ovr_q && !clearOverrun_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            chan_q  <= '0;
            data_q  <= '0;
            out_q   <= '0;
            flag_q  <= 1'b0;
            dec_q   <= '0;
            log2_q  <= '0;
            sync_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            out_q   <= out_d;
            flag_q  <= flag_d;
            dec_q   <= dec_d;
            log2_q  <= log2_d;
            sync_q  <= sync_d;
            ovr_q   <= ovr_d;
        end
    end

    // log2_q changes on the same edge the flagged channel-0 beat appears
    assign shift_full      = 32'(STAGES) * 32'(log2_q);
    assign cicShift_o      = (shift_full > 32'd15) ? 4'd15 : shift_full[3:0];
    assign outputData_o    = out_q;
    assign outputChannel_o = chan_q;
    assign outputValid_o   = (state_q == SHIFT);
    assign busy_o          = (state_q == SHIFT);
    assign decimateFlag_o  = flag_q;
    assign overrun_o       = ovr_q;
endmodule
